// File: rtl/arc_ctrl_pkg.sv
// Shared control types for the arcade halt/pause logic.
package arc_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    WAIT_VBL,
    SETTLE,
    HALTED
  } halt_state_t;

  localparam int unsigned DIM_10S_48M = 480000000;

  function automatic logic is_pause_state(input halt_state_t s);
    return (s == SETTLE) || (s == HALTED);
  endfunction

endpackage

// File: rtl/pause_hs_arbiter_if.sv
// Halt-source inputs and pause/grant/dim outputs of the central halt controller.
interface pause_hs_arbiter_if;

  logic btn_pause;
  logic osd_status;
  logic osd_pause_en;
  logic hs_req;
  logic vblank;
  logic pause;
  logic hs_grant;
  logic dim_video;
  logic user_paused;

  modport master (
    output btn_pause,
    output osd_status,
    output osd_pause_en,
    output hs_req,
    output vblank,
    input  pause,
    input  hs_grant,
    input  dim_video,
    input  user_paused
  );

  modport slave (
    input  btn_pause,
    input  osd_status,
    input  osd_pause_en,
    input  hs_req,
    input  vblank,
    output pause,
    output hs_grant,
    output dim_video,
    output user_paused
  );

endinterface

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector; history register loads LOAD on reset so a
// level already high through reset is not reported as an edge.
module rise_detect #(
  parameter logic LOAD = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= LOAD;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/pause_hs_arbiter.sv
// Central halt controller: merges user/OSD/hiscore halt sources, halts the core
// on a frame boundary, grants the work-RAM port once settled, and dims video.
module pause_hs_arbiter
  import arc_ctrl_pkg::*;
#(
  parameter int unsigned DIM_CYCLES    = DIM_10S_48M,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter bit          SYNC_TO_VBL   = 1'b1
) (
  input logic               clk_sys,
  input logic               reset,
  pause_hs_arbiter_if.slave bus
);

  localparam int TW  = $clog2(DIM_CYCLES + 1);
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TW-1:0]  DIM_MAX     = TW'(DIM_CYCLES);
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);

  halt_state_t    state;
  logic [SCW-1:0] settle_cnt;
  logic [TW-1:0]  dim_cnt;
  logic           btn_rise;
  logic           vbl_rise;
  logic           user_q;
  logic           halt_req;
  logic           quiet;
  logic           pause_q;
  logic           grant_q;
  logic           dim_q;

  rise_detect #(.LOAD(1'b1)) u_btn_rise (
    .clk   (clk_sys),
    .reset (reset),
    .d     (bus.btn_pause),
    .rise  (btn_rise)
  );

  rise_detect #(.LOAD(1'b0)) u_vbl_rise (
    .clk   (clk_sys),
    .reset (reset),
    .d     (bus.vblank),
    .rise  (vbl_rise)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      user_q <= 1'b0;
    end else if (btn_rise) begin
      user_q <= ~user_q;
    end
  end

  assign halt_req = user_q | (bus.osd_status & bus.osd_pause_en) | bus.hs_req;

  // SETTLE ignores halt_req so the core always sees a full settle window.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= RUN;
      settle_cnt <= '0;
      pause_q    <= 1'b0;
      grant_q    <= 1'b0;
    end else begin
      grant_q <= 1'b0;
      case (state)
        RUN: begin
          if (halt_req) begin
            if (SYNC_TO_VBL) begin
              state <= WAIT_VBL;
            end else begin
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
              pause_q    <= 1'b1;
            end
          end
        end
        WAIT_VBL: begin
          if (!halt_req) begin
            state <= RUN;
          end else if (vbl_rise) begin
            state      <= SETTLE;
            settle_cnt <= SETTLE_LOAD;
            pause_q    <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state <= HALTED;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        HALTED: begin
          if (!halt_req) begin
            state   <= RUN;
            pause_q <= 1'b0;
          end else begin
            grant_q <= bus.hs_req;
          end
        end
        default: begin
          state   <= RUN;
          pause_q <= 1'b0;
        end
      endcase
    end
  end

  assign quiet = (state == HALTED) && !bus.hs_req;

  // dim_video is gated by quiet so it drops the cycle after HALTED is left
  // or the hiscore engine takes the port.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dim_cnt <= '0;
      dim_q   <= 1'b0;
    end else if (quiet) begin
      dim_q <= (dim_cnt == DIM_MAX);
      if (dim_cnt != DIM_MAX) begin
        dim_cnt <= dim_cnt + 1'b1;
      end
    end else begin
      dim_cnt <= '0;
      dim_q   <= 1'b0;
    end
  end

  assign bus.pause       = pause_q;
  assign bus.hs_grant    = grant_q;
  assign bus.dim_video   = dim_q;
  assign bus.user_paused = user_q;

endmodule

// File: tb/tb_pause_hs_arbiter.sv
// Directed and randomized checks of pause_hs_arbiter against a timestamp-based model.
module tb_pause_hs_arbiter;

  localparam int DIM    = 100;
  localparam int SETTLE = 4;

  logic clk_sys;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   cyc;

  pause_hs_arbiter_if bus();

  pause_hs_arbiter #(
    .DIM_CYCLES    (DIM),
    .SETTLE_CYCLES (SETTLE),
    .SYNC_TO_VBL   (1'b1)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Model: pause is tracked by the cycle it asserted; halted once SETTLE cycles
  // have elapsed since then. Dim is tracked by when the quiet streak began.
  logic m_hist, m_user, m_vbl_d, m_pause, m_wait, m_grant, m_dim, m_streak;
  int   m_pause_at, m_since;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic step();
    logic hreq, rise, halted, quiet;
    logic n_hist, n_user, n_pause, n_wait, n_grant, n_dim, n_streak;
    int   n_at, n_since;
    n_hist = m_hist; n_user = m_user; n_pause = m_pause; n_wait = m_wait;
    n_streak = m_streak; n_at = m_pause_at; n_since = m_since;
    if (reset) begin
      n_hist = 1'b1; n_user = 1'b0; n_pause = 1'b0; n_wait = 1'b0;
      n_grant = 1'b0; n_dim = 1'b0; n_streak = 1'b0;
    end else begin
      hreq   = m_user | (bus.osd_status & bus.osd_pause_en) | bus.hs_req;
      rise   = bus.vblank & ~m_vbl_d;
      halted = m_pause && (cyc - m_pause_at >= SETTLE);
      n_user = m_user ^ (bus.btn_pause & ~m_hist);
      n_hist = bus.btn_pause;
      if (!m_pause) begin
        if (m_wait) begin
          if (!hreq) n_wait = 1'b0;
          else if (rise) begin
            n_wait = 1'b0; n_pause = 1'b1; n_at = cyc + 1;
          end
        end else if (hreq) begin
          n_wait = 1'b1;
        end
      end else if (halted && !hreq) begin
        n_pause = 1'b0;
      end
      n_grant = halted && bus.hs_req;
      quiet   = halted && !bus.hs_req;
      if (quiet) begin
        if (!m_streak) begin
          n_streak = 1'b1; n_since = cyc;
        end
        n_dim = (cyc - n_since >= DIM);
      end else begin
        n_streak = 1'b0; n_dim = 1'b0;
      end
    end
    m_vbl_d = reset ? 1'b0 : bus.vblank;
    @(posedge clk_sys);
    #1;
    cyc++;
    m_hist = n_hist; m_user = n_user; m_pause = n_pause; m_wait = n_wait;
    m_grant = n_grant; m_dim = n_dim; m_streak = n_streak;
    m_pause_at = n_at; m_since = n_since;
    chk("pause", bus.pause, m_pause);
    chk("hs_grant", bus.hs_grant, m_grant);
    chk("dim_video", bus.dim_video, m_dim);
    chk("user_paused", bus.user_paused, m_user);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic vbl_pulse();
    bus.vblank = 1'b1;
    step();
    bus.vblank = 1'b0;
  endtask

  task automatic btn_pulse();
    bus.btn_pause = 1'b1;
    step();
    bus.btn_pause = 1'b0;
    step();
  endtask

  initial begin
    int vcnt, vper;
    n_checks = 0; n_pass = 0; cyc = 0;
    m_hist = 1'b1; m_user = 1'b0; m_vbl_d = 1'b0; m_pause = 1'b0; m_wait = 1'b0;
    m_grant = 1'b0; m_dim = 1'b0; m_streak = 1'b0; m_pause_at = 0; m_since = 0;
    bus.btn_pause = 1'b0; bus.osd_status = 1'b0; bus.osd_pause_en = 1'b0;
    bus.hs_req = 1'b0; bus.vblank = 1'b0;
    reset = 1'b1;
    steps(2);
    chk("rst_pause", bus.pause, 1'b0);
    chk("rst_grant", bus.hs_grant, 1'b0);
    chk("rst_dim", bus.dim_video, 1'b0);
    chk("rst_user", bus.user_paused, 1'b0);
    reset = 1'b0;
    steps(3);

    // hiscore request halts at vblank, grant after settle, release
    bus.hs_req = 1'b1;
    steps(3);
    vbl_pulse();
    chk("hs_pause_n1", bus.pause, 1'b1);
    steps(4);
    chk("hs_grant_n5", bus.hs_grant, 1'b0);
    step();
    chk("hs_grant_n6", bus.hs_grant, 1'b1);
    steps(10);
    bus.hs_req = 1'b0;
    step();
    chk("hs_rel_grant", bus.hs_grant, 1'b0);
    chk("hs_rel_pause", bus.pause, 1'b0);
    steps(5);

    // user pause, dim after long halt, unpause
    btn_pulse();
    chk("usr_toggle_on", bus.user_paused, 1'b1);
    chk("usr_no_pause_yet", bus.pause, 1'b0);
    steps(3);
    vbl_pulse();
    chk("usr_pause", bus.pause, 1'b1);
    steps(104);
    chk("dim_before", bus.dim_video, 1'b0);
    step();
    chk("dim_after", bus.dim_video, 1'b1);
    bus.btn_pause = 1'b1;
    step();
    bus.btn_pause = 1'b0;
    chk("usr_toggle_off", bus.user_paused, 1'b0);
    step();
    chk("unpause_pause", bus.pause, 1'b0);
    step();
    chk("unpause_dim", bus.dim_video, 1'b0);
    steps(5);

    // OSD open without pause enable, then enable
    bus.osd_status = 1'b1;
    steps(3);
    for (int k = 0; k < 2; k++) begin
      vbl_pulse();
      steps(10);
      chk("osd_dis_pause", bus.pause, 1'b0);
    end
    bus.osd_pause_en = 1'b1;
    steps(4);
    vbl_pulse();
    chk("osd_en_pause", bus.pause, 1'b1);
    bus.osd_status = 1'b0;
    steps(8);
    chk("osd_close_pause", bus.pause, 1'b0);
    bus.osd_pause_en = 1'b0;
    steps(3);

    // halt_req drops in WAIT_VBL on the same cycle as the vblank edge
    bus.hs_req = 1'b1;
    step();
    bus.hs_req = 1'b0;
    vbl_pulse();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("drop_wait_pause", bus.pause, 1'b0);
    end

    // user paused and dimmed, hiscore request overlaps
    btn_pulse();
    vbl_pulse();
    steps(110);
    chk("ovl_dim_on", bus.dim_video, 1'b1);
    bus.hs_req = 1'b1;
    step();
    chk("ovl_dim_off", bus.dim_video, 1'b0);
    chk("ovl_grant", bus.hs_grant, 1'b1);
    chk("ovl_pause", bus.pause, 1'b1);
    steps(5);
    bus.hs_req = 1'b0;
    step();
    chk("ovl_grant_off", bus.hs_grant, 1'b0);
    chk("ovl_still_halt", bus.pause, 1'b1);
    steps(99);
    chk("ovl_redim_before", bus.dim_video, 1'b0);
    step();
    chk("ovl_redim_after", bus.dim_video, 1'b1);
    btn_pulse();
    steps(5);

    // button held through reset, then reset during SETTLE
    bus.btn_pause = 1'b1;
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    steps(3);
    chk("held_btn_user", bus.user_paused, 1'b0);
    bus.btn_pause = 1'b0;
    steps(2);
    chk("held_btn_user2", bus.user_paused, 1'b0);
    bus.hs_req = 1'b1;
    steps(2);
    vbl_pulse();
    step();
    chk("settle_pause", bus.pause, 1'b1);
    reset = 1'b1;
    step();
    chk("rst_settle_pause", bus.pause, 1'b0);
    chk("rst_settle_grant", bus.hs_grant, 1'b0);
    chk("rst_settle_dim", bus.dim_video, 1'b0);
    reset = 1'b0;
    bus.hs_req = 1'b0;
    steps(3);

    // randomized traffic
    vcnt = 0;
    vper = 40;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 89) == 0) bus.btn_pause = ~bus.btn_pause;
      if ($urandom_range(0, 199) == 0) bus.osd_status = ~bus.osd_status;
      if ($urandom_range(0, 149) == 0) bus.osd_pause_en = ~bus.osd_pause_en;
      if ($urandom_range(0, 119) == 0) bus.hs_req = ~bus.hs_req;
      vcnt++;
      if (vcnt >= vper) begin
        vcnt = 0;
        vper = 30 + $urandom_range(0, 30);
      end
      bus.vblank = (vcnt < 4);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
